// File: rtl/uart_echo_engine.sv
// -----------------------------------------------------------------------------
// uart_echo_engine
//
// Echoes words from a UART receive FIFO back into a UART transmit FIFO. Each
// echoed word is the received word plus OFFSET, with the sum wrapping modulo
// 2^DBIT. The engine has two modes:
//   auto_mode = 1 : echo continuously while words are available.
//   auto_mode = 0 : echo one word per single-cycle step tick.
//
// Per-word sequence (a three-state FSM):
//   IDLE  : wait for a word and a request (auto_mode or step).
//   FETCH : pop the receive FIFO for one cycle and capture head + OFFSET.
//   SEND  : push the captured word once tx_full is low. Wait here while the
//           transmit FIFO is full.
//
// A step tick that arrives while a word is in flight is dropped, not queued.
// A step tick that arrives while the receive FIFO is empty is also dropped.
//
// Optional feature (macro UART_ECHO_STATS_EN):
//   When the macro is defined, the rx_count and tx_count ports and their
//   counters are present. When it is undefined, both ports and the counter
//   logic are absent. All other behaviour is the same in both builds.
//
// Ports
//   clk        in   1      system clock, all state updates on the rising edge
//   reset      in   1      asynchronous, active-high reset
//   step       in   1      single-cycle tick that requests one echo (step mode)
//   auto_mode  in   1      1 = echo continuously, 0 = one echo per step tick
//   rx_empty   in   1      receive FIFO empty flag
//   r_data     in   DBIT   receive FIFO head word, valid while rx_empty = 0
//   rd_uart    out  1      receive FIFO pop strobe
//   tx_full    in   1      transmit FIFO full flag
//   w_data     out  DBIT   word to the transmit FIFO (always equals data_reg)
//   wr_uart    out  1      transmit FIFO push strobe
//   last_rx    out  DBIT   most recently popped received word
//   busy       out  1      high in any state other than IDLE
//   rx_count   out  CNT_W  popped word count   (UART_ECHO_STATS_EN only)
//   tx_count   out  CNT_W  pushed word count   (UART_ECHO_STATS_EN only)
// -----------------------------------------------------------------------------
module uart_echo_engine #(
  parameter int DBIT   = 8,
  parameter int OFFSET = 1,
  parameter int CNT_W  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            step,
  input  logic            auto_mode,
  input  logic            rx_empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd_uart,
  input  logic            tx_full,
  output logic [DBIT-1:0] w_data,
  output logic            wr_uart,
  output logic [DBIT-1:0] last_rx,
  output logic            busy
`ifdef UART_ECHO_STATS_EN
  ,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] tx_count
`endif
);

  // Reject parameter values that cannot produce a usable datapath.
  if (DBIT < 1) begin : g_bad_dbit
    $error("uart_echo_engine: DBIT must be at least 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("uart_echo_engine: CNT_W must be at least 1");
  end

  // OFFSET is truncated to the word width, so the adder wraps modulo 2^DBIT.
  localparam logic [DBIT-1:0] OFFSET_W = DBIT'(OFFSET);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [DBIT-1:0] data_reg;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) assignments. Every register then
  // samples values from before the edge, and the result does not depend on the
  // order of the always blocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and strobe logic
  //
  // The strobes are decoded from the registered state, so an asynchronous reset
  // deasserts them at once. Each strobe lasts one cycle per word: FETCH is left
  // unconditionally, and SEND is left on the same cycle that wr_uart fires.
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case statement.
  // Without the defaults, any path that skips an assignment would infer a latch.
  always_comb begin
    state_d = state_q;
    rd_uart = 1'b0;
    wr_uart = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Step ticks are only looked at here. Ticks that arrive in FETCH or
        // SEND therefore fall away, and so do ticks that arrive while the
        // receive FIFO is empty. A change of auto_mode also takes effect here,
        // so it never cuts a word short.
        if (!rx_empty && (auto_mode || step)) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        rd_uart = 1'b1;
        state_d = SEND;
      end

      SEND: begin
        // The captured word is held until the transmit FIFO has room. This
        // keeps exactly one push per pop, however long tx_full stays high.
        if (!tx_full) begin
          wr_uart = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // Datapath: capture the head word during FETCH
  // ---------------------------------------------------------------------------
  // NOTE: these data registers are reset explicitly. The outputs are visible to
  // the user (LEDs and the transmit word), so they must show zero after reset
  // rather than stale contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg <= '0;
      last_rx  <= '0;
    end else if (rd_uart) begin
      data_reg <= r_data + OFFSET_W;
      last_rx  <= r_data;
    end
  end

  // w_data is driven straight from the holding register, so it stays stable
  // for the whole time the engine waits in SEND.
  assign w_data = data_reg;

`ifdef UART_ECHO_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics counters: each counts strobes and wraps modulo 2^CNT_W
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_count <= '0;
      tx_count <= '0;
    end else begin
      if (rd_uart) begin
        rx_count <= rx_count + CNT_W'(1);
      end
      if (wr_uart) begin
        tx_count <= tx_count + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_echo_engine.sv
// -----------------------------------------------------------------------------
// tb_uart_echo_engine
//
// Self-checking bench for uart_echo_engine with DBIT = 8, OFFSET = 1 and
// CNT_W = 16.
//
// The receive FIFO is modelled as a queue of words. Each pop is recorded by the
// scoreboard as an expected echo, (word + OFFSET) mod 256. Each push must then
// match the oldest outstanding echo, in order.
//
// Directed sequences cover:
//   - the per-word latency
//   - wrap-around of the added offset
//   - back-pressure from tx_full
//   - step ticks that must be discarded
//   - reset during SEND
//   - auto-mode throughput
//
// A randomized phase then runs all inputs against the scoreboard.
// -----------------------------------------------------------------------------
module tb_uart_echo_engine;

  localparam int DBIT   = 8;
  localparam int OFFSET = 1;
  localparam int CNT_W  = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            step;
  logic            auto_mode;
  logic            rx_empty;
  logic [DBIT-1:0] r_data;
  logic            rd_uart;
  logic            tx_full;
  logic [DBIT-1:0] w_data;
  logic            wr_uart;
  logic [DBIT-1:0] last_rx;
  logic            busy;
`ifdef UART_ECHO_STATS_EN
  logic [CNT_W-1:0] rx_count;
  logic [CNT_W-1:0] tx_count;
`endif

  uart_echo_engine #(
    .DBIT  (DBIT),
    .OFFSET(OFFSET),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .step     (step),
    .auto_mode(auto_mode),
    .rx_empty (rx_empty),
    .r_data   (r_data),
    .rd_uart  (rd_uart),
    .tx_full  (tx_full),
    .w_data   (w_data),
    .wr_uart  (wr_uart),
    .last_rx  (last_rx),
    .busy     (busy)
`ifdef UART_ECHO_STATS_EN
    ,
    .rx_count (rx_count),
    .tx_count (tx_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural models: the receive FIFO contents and the expected echo stream.
  logic [DBIT-1:0] rx_q[$];
  logic [DBIT-1:0] exp_q[$];
  int tot_rd = 0;
  int tot_wr = 0;

  // Snapshot of the DUT outputs taken in the middle of the most recent cycle.
  logic            s_rd;
  logic            s_wr;
  logic            s_busy;
  logic [DBIT-1:0] s_wdata;
  logic [DBIT-1:0] s_last_rx;

  typedef struct {
    logic [DBIT-1:0] rx;
    logic [DBIT-1:0] exp_w;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Drive rx_empty and r_data from the receive FIFO model.
  task automatic fifo_drive();
    rx_empty = (rx_q.size() == 0);
    r_data   = (rx_q.size() == 0) ? '0 : rx_q[0];
  endtask

  // Finish the current cycle:
  //   1. sample the outputs away from the clock edge;
  //   2. update the scoreboard from the sampled strobes;
  //   3. advance to just past the next rising edge;
  //   4. apply any FIFO pop.
  task automatic tick();
    logic rd;
    logic wr;
    #1;
    rd        = rd_uart;
    wr        = wr_uart;
    s_rd      = rd;
    s_wr      = wr;
    s_busy    = busy;
    s_wdata   = w_data;
    s_last_rx = last_rx;
    check("no_rd_wr_overlap", 32'(rd & wr), 0);
    if (wr) begin
      check("wr_has_pending_word", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        check("echo_data", 32'(w_data), 32'(exp_q.pop_front()));
      end
      tot_wr++;
    end
    if (rd) begin
      check("rd_fifo_nonempty", 32'(rx_q.size() != 0), 1);
      if (rx_q.size() != 0) begin
        exp_q.push_back(8'(rx_q[0] + OFFSET));
      end
      tot_rd++;
    end
    @(posedge clk);
    #1;
    if (rd && rx_q.size() != 0) begin
      void'(rx_q.pop_front());
    end
    fifo_drive();
  endtask

  initial begin
    int rdc;
    int wrc;
    int guard;

    vecs[0] = '{rx: 8'h41, exp_w: 8'h42};
    vecs[1] = '{rx: 8'hFF, exp_w: 8'h00};
    vecs[2] = '{rx: 8'h00, exp_w: 8'h01};
    vecs[3] = '{rx: 8'h7F, exp_w: 8'h80};
    vecs[4] = '{rx: 8'hA5, exp_w: 8'hA6};
    vecs[5] = '{rx: 8'hFE, exp_w: 8'hFF};

    // ---- Reset state --------------------------------------------------------
    reset     = 1'b0;
    step      = 1'b0;
    auto_mode = 1'b0;
    tx_full   = 1'b0;
    fifo_drive();
    #2 reset = 1'b1;
    #1;
    check("reset_rd_uart", 32'(rd_uart), 0);
    check("reset_wr_uart", 32'(wr_uart), 0);
    check("reset_busy",    32'(busy),    0);
    check("reset_w_data",  32'(w_data),  0);
    check("reset_last_rx", 32'(last_rx), 0);
`ifdef UART_ECHO_STATS_EN
    check("reset_rx_count", 32'(rx_count), 0);
    check("reset_tx_count", 32'(tx_count), 0);
`endif
    @(posedge clk);
    #1;
    tick();
    reset = 1'b0;
    tick();

    // ---- Step mode: table of words, with latency checked per word -----------
    for (int i = 0; i < 6; i++) begin
      rx_q.push_back(vecs[i].rx);
      fifo_drive();
      step = 1'b1;
      tick();                                  // cycle n: request
      check("step_n_rd", 32'(s_rd), 0);
      step = 1'b0;
      tick();                                  // cycle n+1: pop
      check("step_n1_rd", 32'(s_rd), 1);
      check("step_n1_wr", 32'(s_wr), 0);
      tick();                                  // cycle n+2: push
      check("step_n2_wr",      32'(s_wr),      1);
      check("step_n2_rd",      32'(s_rd),      0);
      check("step_n2_w_data",  32'(s_wdata),   32'(vecs[i].exp_w));
      check("step_n2_last_rx", 32'(s_last_rx), 32'(vecs[i].rx));
      tick();                                  // cycle n+3: idle again
      check("step_n3_wr",   32'(s_wr),   0);
      check("step_n3_busy", 32'(s_busy), 0);
    end

    // ---- Back-pressure: tx_full held high for 10 cycles in SEND -------------
    rx_q.push_back(8'h10);
    fifo_drive();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();                                    // FETCH
    tx_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_wr_held",   32'(s_wr),    0);
      check("bp_w_data",    32'(s_wdata), 'h11);
      check("bp_busy",      32'(s_busy),  1);
    end
    tx_full = 1'b0;
    tick();
    check("bp_release_wr", 32'(s_wr),    1);
    check("bp_release_wd", 32'(s_wdata), 'h11);
    tick();
    check("bp_single_wr",  32'(s_wr),   0);
    check("bp_idle",       32'(s_busy), 0);

    // ---- Step ticks while busy are discarded --------------------------------
    rx_q.push_back(8'h20);
    rx_q.push_back(8'h30);
    fifo_drive();
    step = 1'b1;
    tick();                                    // request
    tick();                                    // FETCH, tick ignored
    tick();                                    // SEND, tick ignored
    step = 1'b0;
    rdc = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      rdc += int'(s_rd) + int'(s_wr);
    end
    check("busy_step_discarded", 32'(rdc), 0);
    check("busy_step_word_left", 32'(rx_q.size()), 1);
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (3) tick();
    check("busy_step_drained", 32'(rx_q.size()), 0);

    // ---- Step with rx_empty = 1 is discarded -------------------------------
    step = 1'b1;
    tick();
    step = 1'b0;
    rdc = int'(s_rd) + int'(s_wr);
    for (int i = 0; i < 3; i++) begin
      tick();
      rdc += int'(s_rd) + int'(s_wr);
    end
    check("empty_step_no_strobes", 32'(rdc), 0);

    // ---- Reset asserted while waiting in SEND ------------------------------
    rx_q.push_back(8'h55);
    fifo_drive();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();                                    // FETCH
    tx_full = 1'b1;
    tick();                                    // waiting in SEND
    check("rst_send_busy", 32'(s_busy), 1);
    reset = 1'b1;
    #1;
    check("rst_send_wr",      32'(wr_uart), 0);
    check("rst_send_rd",      32'(rd_uart), 0);
    check("rst_send_busy0",   32'(busy),    0);
    check("rst_send_w_data",  32'(w_data),  0);
    check("rst_send_last_rx", 32'(last_rx), 0);
    check("rst_abandoned_word", 32'(exp_q.size()), 1);
    exp_q.delete();
    tot_rd = 0;
    tot_wr = 0;
    tick();
    tx_full = 1'b0;
    tick();
    reset = 1'b0;
    wrc = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      wrc += int'(s_wr) + int'(s_rd);
    end
    check("rst_no_strobe_after", 32'(wrc), 0);
`ifdef UART_ECHO_STATS_EN
    check("rst_rx_count", 32'(rx_count), 0);
    check("rst_tx_count", 32'(tx_count), 0);
`endif

    // ---- Auto mode: four queued words within 12 cycles ----------------------
    rx_q.push_back(8'h10);
    rx_q.push_back(8'h7F);
    rx_q.push_back(8'hFF);
    rx_q.push_back(8'hC3);
    fifo_drive();
    auto_mode = 1'b1;
    rdc = 0;
    wrc = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      rdc += int'(s_rd);
      wrc += int'(s_wr);
    end
    auto_mode = 1'b0;
    check("auto_rd_count",  32'(rdc), 4);
    check("auto_wr_count",  32'(wrc), 4);
    check("auto_all_echoed", 32'(exp_q.size()), 0);
`ifdef UART_ECHO_STATS_EN
    check("auto_rx_count", 32'(rx_count), 4);
    check("auto_tx_count", 32'(tx_count), 4);
`endif

    // ---- Randomized traffic against the scoreboard --------------------------
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0 && rx_q.size() < 8) begin
        rx_q.push_back(8'($urandom));
        fifo_drive();
      end
      if ($urandom_range(0, 19) == 0) begin
        auto_mode = ~auto_mode;
      end
      step    = ($urandom_range(0, 4) == 0);
      tx_full = ($urandom_range(0, 9) < 3);
      tick();
    end

    // Drain whatever is left.
    step      = 1'b0;
    tx_full   = 1'b0;
    auto_mode = 1'b1;
    guard     = 0;
    while ((rx_q.size() != 0 || exp_q.size() != 0 || s_busy) && guard < 200) begin
      tick();
      guard++;
    end
    check("drain_within_bound", 32'(guard < 200), 1);
    check("drain_exp_empty",    32'(exp_q.size()), 0);
    check("rd_wr_balanced",     32'(tot_wr), 32'(tot_rd));
`ifdef UART_ECHO_STATS_EN
    check("final_rx_count", 32'(rx_count), 32'(16'(tot_rd)));
    check("final_tx_count", 32'(tx_count), 32'(16'(tot_wr)));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
